// File: rtl/btn_conditioner.sv
// Two-button conditioner: synchronizes, debounces and edge-detects two raw
// buttons into one-cycle step pulses, with optional hold-to-repeat.
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   btn_left_raw, btn_right_raw   asynchronous bouncy button inputs
//   btn_left, btn_right           one-cycle step pulses (never both high)
//   left_level, right_level       debounced button levels
//
// Build option: define BTN_AUTO_REPEAT_EN to compile in the per-button
// IDLE/DELAY/REPEAT auto-repeat FSMs and their timers.
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_left_raw,
    input  logic btn_right_raw,
    output logic btn_left,
    output logic btn_right,
    output logic left_level,
    output logic right_level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);

    // Index 0 is the left button, index 1 the right button.
    logic [1:0]    raw;
    logic [1:0]    meta;
    logic [1:0]    sync;
    logic [1:0]    level;
    logic [1:0]    level_d;
    logic [1:0]    press;
    logic [1:0]    fire;
    logic [1:0]    step;
    logic          both;
    logic [CW-1:0] cnt [2];

    assign raw = {btn_right_raw, btn_left_raw};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            sync <= '0;
        end else begin
            meta <= raw;
            sync <= meta;
        end
    end

    // The counter runs only while the synchronized input disagrees with the
    // accepted level; reaching DEBOUNCE_CYCLES flips the level and restarts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= '0;
            for (int i = 0; i < 2; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync[i] == level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    level[i] <= ~level[i];
                    cnt[i]   <= '0;
                end else if (cnt[i] != CNT_MAX) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_d <= '0;
            step    <= '0;
        end else begin
            level_d <= level;
            step    <= fire;
        end
    end

    assign press = level & ~level_d;
    // With both buttons down neither may step; this also keeps the two
    // outputs mutually exclusive, since any pulse needs its own level high.
    assign both  = &level;

`ifdef BTN_AUTO_REPEAT_EN
    localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY
                                                       : REPEAT_RATE;
    localparam int TW = $clog2(TMAX + 1);
    // Timers count down to zero; the pulse is registered one edge later,
    // so loads are one short of the nominal interval.
    localparam logic [TW-1:0] DELAY_LOAD = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] RATE_LOAD  = TW'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } state_t;

    state_t        state    [2];
    state_t        state_nx [2];
    logic [TW-1:0] timer    [2];
    logic [TW-1:0] timer_nx [2];
    logic [1:0]    rep;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                state[i] <= IDLE;
                timer[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                state[i] <= state_nx[i];
                timer[i] <= timer_nx[i];
            end
        end
    end

    always_comb begin
        rep = '0;
        for (int i = 0; i < 2; i++) begin
            state_nx[i] = state[i];
            timer_nx[i] = timer[i];
            if (!level[i] || both) begin
                state_nx[i] = IDLE;
                timer_nx[i] = '0;
            end else begin
                unique case (state[i])
                    IDLE: begin
                        if (press[i]) begin
                            state_nx[i] = DELAY;
                            timer_nx[i] = DELAY_LOAD;
                        end
                    end
                    DELAY, REPEAT: begin
                        if (timer[i] == '0) begin
                            rep[i]      = 1'b1;
                            state_nx[i] = REPEAT;
                            timer_nx[i] = RATE_LOAD;
                        end else begin
                            timer_nx[i] = timer[i] - 1'b1;
                        end
                    end
                    default: begin
                        state_nx[i] = IDLE;
                        timer_nx[i] = '0;
                    end
                endcase
            end
        end
    end

    assign fire = {2{~both}} & (press | rep);
`else
    assign fire = {2{~both}} & press;
`endif

    assign btn_left    = step[0];
    assign btn_right   = step[1];
    assign left_level  = level[0];
    assign right_level = level[1];

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20,
// REPEAT_RATE=8, 10 ns clock); expectations follow BTN_AUTO_REPEAT_EN.
module tb_btn_conditioner;

    logic clk;
    logic rst;
    logic btn_left_raw;
    logic btn_right_raw;
    logic btn_left;
    logic btn_right;
    logic left_level;
    logic right_level;

    int checks;
    int failures;
    int e;
    int overlap;
    logic lprev;
    logic rprev;
    int lq[$];
    int rq[$];
    int lrise[$];
    int lfall[$];
    int rrise[$];
    int exp_l[$];

    btn_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY(20),
        .REPEAT_RATE(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_left_raw(btn_left_raw),
        .btn_right_raw(btn_right_raw),
        .btn_left(btn_left),
        .btn_right(btn_right),
        .left_level(left_level),
        .right_level(right_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    // Advance one edge and log pulse/level events against edge number e.
    task automatic cyc_step();
        @(posedge clk);
        #1;
        e++;
        if (btn_left) lq.push_back(e);
        if (btn_right) rq.push_back(e);
        if (btn_left && btn_right) overlap++;
        if (left_level && !lprev) lrise.push_back(e);
        if (!left_level && lprev) lfall.push_back(e);
        if (right_level && !rprev) rrise.push_back(e);
        lprev = left_level;
        rprev = right_level;
    endtask

    task automatic clear();
        lq.delete();
        rq.delete();
        lrise.delete();
        lfall.delete();
        rrise.delete();
        e = 0;
        lprev = left_level;
        rprev = right_level;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        btn_left_raw = 1'b1;
        btn_right_raw = 1'b1;
        repeat (3) cyc_step();
        chk(tag, int'({btn_left, btn_right, left_level, right_level}), 0);
        btn_left_raw = 1'b0;
        btn_right_raw = 1'b0;
        rst = 1'b0;
        repeat (8) cyc_step();
        clear();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        overlap = 0;
        e = 0;
        lprev = 1'b0;
        rprev = 1'b0;
        rst = 1'b1;
        btn_left_raw = 1'b0;
        btn_right_raw = 1'b0;

        // Clean left press, held 20 cycles.
        do_reset("rst_s1");
        btn_left_raw = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (e == 20) btn_left_raw = 1'b0;
            cyc_step();
        end
        chk("s1_lcnt", lq.size(), 1);
        chk("s1_lpulse", qget(lq, 0), 7);
        chk("s1_lrise", qget(lrise, 0), 6);
        chk("s1_lfall", qget(lfall, 0), 26);
        chk("s1_rcnt", rq.size(), 0);

        // Right bounces every 2 cycles for 20 cycles, then held.
        do_reset("rst_s2");
        for (int k = 0; k < 50; k++) begin
            if (e < 20) btn_right_raw = ((e % 4) < 2);
            else btn_right_raw = (e < 30);
            cyc_step();
        end
        chk("s2_rcnt", rq.size(), 1);
        chk("s2_rpulse", qget(rq, 0), 27);
        chk("s2_rrise_n", rrise.size(), 1);
        chk("s2_rrise", qget(rrise, 0), 26);
        chk("s2_lcnt", lq.size(), 0);

        // Long left hold: 60 cycles.
        do_reset("rst_s3");
`ifdef BTN_AUTO_REPEAT_EN
        exp_l = '{7, 27, 35, 43, 51, 59};
`else
        exp_l = '{7};
`endif
        btn_left_raw = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (e == 60) btn_left_raw = 1'b0;
            cyc_step();
        end
        chk("s3_lcnt", lq.size(), exp_l.size());
        for (int i = 0; i < exp_l.size(); i++) begin
            chk($sformatf("s3_lpulse%0d", i), qget(lq, i), exp_l[i]);
        end
        chk("s3_rcnt", rq.size(), 0);

        // Left pressed, right 5 cycles later, both held.
        do_reset("rst_s4");
        for (int k = 0; k < 80; k++) begin
            btn_left_raw = (e < 40);
            btn_right_raw = (e >= 5) && (e < 45);
            if (e == 20) begin
                chk("s4_levels", int'({left_level, right_level}), 3);
                chk("s4_steps", int'({btn_left, btn_right}), 0);
            end
            cyc_step();
        end
        chk("s4_lcnt", lq.size(), 1);
        chk("s4_lpulse", qget(lq, 0), 7);
        chk("s4_rrise", qget(rrise, 0), 11);
        chk("s4_rcnt", rq.size(), 0);

        // Reset for 5 cycles in the middle of a left hold.
        do_reset("rst_s5");
        btn_left_raw = 1'b1;
        for (int k = 0; k < 70; k++) begin
            if (e == 10) begin
                rst = 1'b1;
                #1;
                chk("s5_rst_async",
                    int'({btn_left, btn_right, left_level, right_level}), 0);
            end
            if (e == 15) rst = 1'b0;
            if (e == 35) btn_left_raw = 1'b0;
            cyc_step();
        end
        chk("s5_lcnt", lq.size(), 2);
        chk("s5_lpulse0", qget(lq, 0), 7);
        chk("s5_lpulse1", qget(lq, 1), 22);
        chk("s5_lrise1", qget(lrise, 1), 21);
        chk("s5_rcnt", rq.size(), 0);

        chk("no_overlap", overlap, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
